// File: rtl/multi_pkg.sv
// Shared types and helpers for the sequential multiplier and its ALU neighbours.
package multi_pkg;

  // Multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

  localparam int MAX_W = 32;

  // Two's-complement magnitude of a sign-extended operand. Callers sign-extend
  // to MAX_W and truncate the result back to their own width; the most
  // negative value maps to 2^(W-1), which still fits W bits unsigned.
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/twos_neg_n_bit.sv
// Conditional two's-complement negate; also used by the ALU subtract path.
module twos_neg_n_bit #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  // Invert-and-increment when neg is set, pass through otherwise
  always_comb begin
    y = neg ? (~x + W'(1)) : x;
  end

endmodule

// File: rtl/multi_seq_n_bit.sv
// Sequential shift-add multiplier: one 2*WIDTH adder, WIDTH+1 cycles per op.
// Magnitudes are multiplied and the sign is applied once at the end.
module multi_seq_n_bit
  import multi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int P_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [P_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_W-1:0]     p_q, p_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [MAX_W-1:0]   a_ext, b_ext;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [P_W-1:0]     addend;
  logic [P_W-1:0]     acc_fin;

  // Operand magnitudes: sign-extend only in signed mode so unsigned values
  // with the top bit set pass through abs_n untouched
  always_comb begin
    a_ext = {MAX_W{a[WIDTH-1] & signed_mode}};
    b_ext = {MAX_W{b[WIDTH-1] & signed_mode}};
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
    a_mag = WIDTH'(abs_n(a_ext));
    b_mag = WIDTH'(abs_n(b_ext));
  end

  // Partial product for this step; the multiplier is shifted right each step
  // so its LSB is always the bit at position cnt
  always_comb begin
    addend = mplier_q[0] ? (P_W'(mcand_q) << cnt_q) : '0;
  end

  twos_neg_n_bit #(.W(P_W)) u_neg (
    .x   (acc_q),
    .neg (neg_q),
    .y   (acc_fin)
  );

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_q + addend;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        // A zero magnitude negates to zero, so neg needs no special case
        p_d     = acc_fin;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_multi_seq_n_bit.sv
// Directed bench for multi_seq_n_bit: WIDTH=8 vector table, back-to-back,
// mid-op reset, plus a WIDTH=16 instance with a golden-model sweep.
module tb_multi_seq_n_bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic        busy16, done16;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last8  = '0;
  logic [31:0] last16 = '0;

  always #5 clk = ~clk;

  multi_seq_n_bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
  );

  multi_seq_n_bit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .p(p16), .busy(busy16), .done(done16)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after the accept edge (#1 past it); walks the 8 RUN/SIGN
  // edges then checks the done cycle.
  task automatic wait_res8(input logic [15:0] exp, input string nm);
    chk({nm, "_busy_acc"}, {31'd0, busy8}, 32'd1);
    chk({nm, "_done_acc"}, {31'd0, done8}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk({nm, "_busy_run"}, {31'd0, busy8}, 32'd1);
      chk({nm, "_done_run"}, {31'd0, done8}, 32'd0);
      chk({nm, "_p_hold"}, {16'd0, p8}, {16'd0, last8});
    end
    @(posedge clk); #1;
    chk({nm, "_done"}, {31'd0, done8}, 32'd1);
    chk({nm, "_busy_done"}, {31'd0, busy8}, 32'd0);
    chk({nm, "_p"}, {16'd0, p8}, {16'd0, exp});
    last8 = exp;
  endtask

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    // perturb inputs while busy; the in-flight op must not see them
    start8 = 1'b0; sm8 = ~sm; a8 = ~a; b8 = ~b;
    wait_res8(exp, nm);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'd0, done8}, 32'd0);
    chk({nm, "_p_after"}, {16'd0, p8}, {16'd0, exp});
  endtask

  task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk({nm, "_busy_run"}, {31'd0, busy16}, 32'd1);
      chk({nm, "_done_run"}, {31'd0, done16}, 32'd0);
      chk({nm, "_p_hold"}, p16, last16);
    end
    @(posedge clk); #1;
    chk({nm, "_done"}, {31'd0, done16}, 32'd1);
    chk({nm, "_busy_done"}, {31'd0, busy16}, 32'd0);
    chk({nm, "_p"}, p16, exp);
    last16 = exp;
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd1,   8'd22,  16'h0016, "u_1x22"};
    vecs[1] = '{1'b0, 8'd7,   8'd10,  16'h0046, "u_7x10"};
    vecs[2] = '{1'b0, 8'd255, 8'd255, 16'hFE01, "u_255x255"};
    vecs[3] = '{1'b0, 8'd0,   8'd200, 16'h0000, "u_0x200"};
    vecs[4] = '{1'b0, 8'd128, 8'd2,   16'h0100, "u_128x2"};
    vecs[5] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF, "s_m1x1"};
    vecs[6] = '{1'b1, 8'h80,  8'h80,  16'h4000, "s_m128xm128"};
    vecs[7] = '{1'b1, 8'h80,  8'h7F,  16'hC080, "s_m128x127"};
    vecs[8] = '{1'b1, 8'h05,  8'hFD,  16'hFFF1, "s_5xm3"};
    vecs[9] = '{1'b1, 8'h00,  8'hFB,  16'h0000, "s_0xm5"};

    // reset state
    #3;
    chk("rst_p", {16'd0, p8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_p16", p16, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run8(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

    // back-to-back with start held high; operands change mid-op
    @(posedge clk); #1;
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    @(posedge clk); #1;
    a8 = 8'd9; b8 = 8'd9;
    wait_res8(16'd15, "b2b_1");
    @(posedge clk); #1;
    a8 = 8'd2; b8 = 8'd100;
    wait_res8(16'd81, "b2b_2");
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_res8(16'd200, "b2b_3");
    @(posedge clk); #1;
    chk("b2b_end_done", {31'd0, done8}, 32'd0);
    chk("b2b_end_busy", {31'd0, busy8}, 32'd0);

    // reset during RUN cycle 4: everything clears at once, no late done
    @(posedge clk); #1;
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd12; b8 = 8'd12;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_p", {16'd0, p8}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mid_rst_done", {31'd0, done8}, 32'd0);
    last8 = '0;
    last16 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", {31'd0, done8}, 32'd0);
      chk("post_rst_idle", {31'd0, busy8}, 32'd0);
    end
    run8(1'b0, 8'd12, 8'd12, 16'd144, "post_rst_op");

    // WIDTH=16 instance
    run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_max");
    run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "w16_minmin");
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      logic [31:0] ea, eb, ex;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = i[0];
      if (rs) begin
        ea = {{16{ra[15]}}, ra};
        eb = {{16{rb[15]}}, rb};
      end else begin
        ea = {16'd0, ra};
        eb = {16'd0, rb};
      end
      ex = ea * eb;
      run16(rs, ra, rb, ex, "w16_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
